mc_controller_ext: RTL and testbench

Next-generation multicycle MIPS control unit: main FSM plus ALU decoder, driving the shared-memory datapath (PC, IR, register file, ALU, single instruction/data memory).
Adds full 6-bit funct decode and optional BNE/ADDI/J support, selected by parameter.
Adds a memready handshake so that memory may take a variable number of cycles.
Also flags unsupported opcode/funct encodings.

---
 rtl/mc_controller_ext.sv | 182 ++++++++++++++++++
 tb/tb_mc_controller_ext.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller_ext.sv
// Multicycle MIPS control unit: main FSM plus ALU decoder for the shared
// instruction/data memory datapath. Memory accesses can stretch over several
// cycles via memready. Unsupported opcodes/functs raise a one-cycle illegal pulse.
module mc_controller_ext #(
   parameter int USE_MEMREADY = 1,
   parameter int ENABLE_BNE   = 1,
   parameter int ENABLE_ADDI  = 1,
   parameter int ENABLE_J     = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       memready,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       alusrca,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEX   = 4'd6,
      S_RTWB   = 4'd7,
      S_BEQ    = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JMP    = 4'd11,
      S_BNE    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t     state_reg;
   state_t     state_next;
   logic       mem_ok;
   logic [2:0] funct_alu;
   logic       funct_ok;

   // Single-cycle memory builds simply treat every access as completing at once.
   assign mem_ok = (USE_MEMREADY != 0) ? memready : 1'b1;
   assign state  = state_reg;

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= S_FETCH;
      else       state_reg <= state_next;
   end

   // R-type funct decode; unsupported functs fall back to add and are flagged.
   always_comb begin
      funct_alu = ALU_ADD;
      funct_ok  = 1'b1;
      case (funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_ok  = 1'b0;
      endcase
   end

   // Next-state and Moore-style control outputs (plus memready/zero/funct qualifiers).
   always_comb begin
      state_next = S_FETCH;
      pcen       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = ALU_ADD;
      illegal    = 1'b0;
      case (state_reg)
         S_FETCH: begin
            alusrcb    = 2'b01;
            irwrite    = mem_ok;
            pcen       = mem_ok;
            state_next = mem_ok ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            if (op == OP_LW || op == OP_SW)               state_next = S_MEMADR;
            else if (op == OP_RTYPE)                      state_next = S_RTEX;
            else if (op == OP_BEQ)                        state_next = S_BEQ;
            else if (op == OP_BNE  && ENABLE_BNE  != 0)   state_next = S_BNE;
            else if (op == OP_ADDI && ENABLE_ADDI != 0)   state_next = S_ADDIEX;
            else if (op == OP_J    && ENABLE_J    != 0)   state_next = S_JMP;
            else begin
               illegal    = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord       = 1'b1;
            state_next = mem_ok ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            memwrite   = 1'b1;
            state_next = mem_ok ? S_FETCH : S_MEMWR;
         end
         S_RTEX: begin
            alusrca    = 1'b1;
            alucontrol = funct_alu;
            state_next = S_RTWB;
         end
         S_RTWB: begin
            regdst   = 1'b1;
            regwrite = funct_ok;
            illegal  = ~funct_ok;
         end
         S_BEQ: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = 2'b01;
            pcen       = zero;
         end
         S_BNE: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = 2'b01;
            pcen       = ~zero;
         end
         S_ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            state_next = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite = 1'b1;
         end
         S_JMP: begin
            pcsrc = 2'b10;
            pcen  = 1'b1;
         end
         default: state_next = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_mc_controller_ext.sv
// Scoreboard bench for mc_controller_ext: the stimulus process pushes the
// hand-computed expected output word for each cycle; a negedge monitor pops
// and compares. Two instances cover the default and the reduced configuration.
module tb_mc_controller_ext;

   typedef struct {
      bit          sel;
      logic [19:0] exp;
      string       name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       memready = 1'b1;

   logic       a_pcen, a_memwrite, a_irwrite, a_regwrite, a_alusrca, a_iord, a_memtoreg, a_regdst, a_illegal;
   logic [1:0] a_alusrcb, a_pcsrc;
   logic [2:0] a_alucontrol;
   logic [3:0] a_state;
   logic       b_pcen, b_memwrite, b_irwrite, b_regwrite, b_alusrca, b_iord, b_memtoreg, b_regdst, b_illegal;
   logic [1:0] b_alusrcb, b_pcsrc;
   logic [2:0] b_alucontrol;
   logic [3:0] b_state;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_bad = 0;
   exp_t        cur;
   logic [19:0] got;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                          OP_J = 6'b000010, OP_BAD = 6'b000011;

   always #5 clk = ~clk;

   mc_controller_ext dut_a (
      .clk(clk), .reset(rst), .op(op), .funct(funct), .zero(zero), .memready(memready),
      .pcen(a_pcen), .memwrite(a_memwrite), .irwrite(a_irwrite), .regwrite(a_regwrite),
      .alusrca(a_alusrca), .iord(a_iord), .memtoreg(a_memtoreg), .regdst(a_regdst),
      .alusrcb(a_alusrcb), .pcsrc(a_pcsrc), .alucontrol(a_alucontrol),
      .illegal(a_illegal), .state(a_state)
   );

   mc_controller_ext #(.USE_MEMREADY(0), .ENABLE_BNE(0), .ENABLE_ADDI(1), .ENABLE_J(1)) dut_b (
      .clk(clk), .reset(rst), .op(op), .funct(funct), .zero(zero), .memready(memready),
      .pcen(b_pcen), .memwrite(b_memwrite), .irwrite(b_irwrite), .regwrite(b_regwrite),
      .alusrca(b_alusrca), .iord(b_iord), .memtoreg(b_memtoreg), .regdst(b_regdst),
      .alusrcb(b_alusrcb), .pcsrc(b_pcsrc), .alucontrol(b_alucontrol),
      .illegal(b_illegal), .state(b_state)
   );

   // Output word: {state, pcen, memwrite, irwrite, regwrite, alusrca, iord,
   //               memtoreg, regdst, alusrcb, pcsrc, alucontrol, illegal}
   function automatic logic [19:0] mk(input logic [3:0] s, input logic pe, input logic mw,
                                      input logic iw, input logic rw, input logic sa,
                                      input logic io, input logic mt, input logic rd,
                                      input logic [1:0] sbv, input logic [1:0] pcs,
                                      input logic [2:0] ac, input logic il);
      return {s, pe, mw, iw, rw, sa, io, mt, rd, sbv, pcs, ac, il};
   endfunction

   logic [19:0] e_fetch, e_fetch_wait, e_decode, e_decode_ill, e_memadr, e_memrd, e_memwb,
                e_memwr, e_rtex_slt, e_rtex_sub, e_rtex_bad, e_rtwb, e_rtwb_ill, e_beq_t,
                e_beq_f, e_bne_t, e_bne_f, e_addiex, e_addiwb, e_jmp;

   // Monitor: one compare per cycle while expectations are pending.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         got = cur.sel ?
               {b_state, b_pcen, b_memwrite, b_irwrite, b_regwrite, b_alusrca, b_iord,
                b_memtoreg, b_regdst, b_alusrcb, b_pcsrc, b_alucontrol, b_illegal} :
               {a_state, a_pcen, a_memwrite, a_irwrite, a_regwrite, a_alusrca, a_iord,
                a_memtoreg, a_regdst, a_alusrcb, a_pcsrc, a_alucontrol, a_illegal};
         n_vec++;
         if (got !== cur.exp) begin
            n_bad++;
            $display("FAIL %s: got %05h expected %05h", cur.name, got, cur.exp);
         end else begin
            $display("ok   %-18s dut%0d state=%0d word=%05h", cur.name, cur.sel, got[19:16], got);
         end
      end
   end

   task automatic step(input bit sel, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic mr, input logic [19:0] e, input string nm);
      op       = o;
      funct    = f;
      zero     = z;
      memready = mr;
      sb.push_back('{sel, e, nm});
      @(posedge clk);
      #1;
   endtask

   initial begin
      //                 st    pe mw iw rw sa io mt rd srcb   pcsrc  aluc    il
      e_fetch      = mk(4'd0,  1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
      e_fetch_wait = mk(4'd0,  0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
      e_decode     = mk(4'd1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0);
      e_decode_ill = mk(4'd1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 1);
      e_memadr     = mk(4'd2,  0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 3'b010, 0);
      e_memrd      = mk(4'd3,  0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0);
      e_memwb      = mk(4'd4,  0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0);
      e_memwr      = mk(4'd5,  0, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0);
      e_rtex_slt   = mk(4'd6,  0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b111, 0);
      e_rtex_sub   = mk(4'd6,  0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b110, 0);
      e_rtex_bad   = mk(4'd6,  0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
      e_rtwb       = mk(4'd7,  0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 0);
      e_rtwb_ill   = mk(4'd7,  0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 1);
      e_beq_t      = mk(4'd8,  1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 3'b110, 0);
      e_beq_f      = mk(4'd8,  0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 3'b110, 0);
      e_bne_t      = mk(4'd12, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 3'b110, 0);
      e_bne_f      = mk(4'd12, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 3'b110, 0);
      e_addiex     = mk(4'd9,  0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 3'b010, 0);
      e_addiwb     = mk(4'd10, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
      e_jmp        = mk(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 0);

      @(posedge clk);
      #1;
      // Reset state: FETCH outputs are the reset values.
      step(0, OP_LW, 6'd0, 0, 1, e_fetch, "reset_fetch");
      rst = 1'b0;

      // lw, memready always high: 0,1,2,3,4
      step(0, OP_LW, 6'd0, 0, 1, e_fetch,  "lw_fetch");
      step(0, OP_LW, 6'd0, 0, 1, e_decode, "lw_decode");
      step(0, OP_LW, 6'd0, 0, 1, e_memadr, "lw_memadr");
      step(0, OP_LW, 6'd0, 0, 1, e_memrd,  "lw_memrd");
      step(0, OP_LW, 6'd0, 0, 1, e_memwb,  "lw_memwb");

      // sw with 3 wait cycles in MEMWR: memwrite held 4 cycles
      step(0, OP_SW, 6'd0, 0, 1, e_fetch,  "sw_fetch");
      step(0, OP_SW, 6'd0, 0, 1, e_decode, "sw_decode");
      step(0, OP_SW, 6'd0, 0, 1, e_memadr, "sw_memadr");
      step(0, OP_SW, 6'd0, 0, 0, e_memwr,  "sw_memwr_w1");
      step(0, OP_SW, 6'd0, 0, 0, e_memwr,  "sw_memwr_w2");
      step(0, OP_SW, 6'd0, 0, 0, e_memwr,  "sw_memwr_w3");
      step(0, OP_SW, 6'd0, 0, 1, e_memwr,  "sw_memwr_done");

      // R-type slt, then unsupported funct, then sub
      step(0, OP_R, 6'b101010, 0, 1, e_fetch,    "slt_fetch");
      step(0, OP_R, 6'b101010, 0, 1, e_decode,   "slt_decode");
      step(0, OP_R, 6'b101010, 0, 1, e_rtex_slt, "slt_rtex");
      step(0, OP_R, 6'b101010, 0, 1, e_rtwb,     "slt_rtwb");
      step(0, OP_R, 6'b000111, 0, 1, e_fetch,    "badf_fetch");
      step(0, OP_R, 6'b000111, 0, 1, e_decode,   "badf_decode");
      step(0, OP_R, 6'b000111, 0, 1, e_rtex_bad, "badf_rtex");
      step(0, OP_R, 6'b000111, 0, 1, e_rtwb_ill, "badf_rtwb");
      step(0, OP_R, 6'b100010, 0, 1, e_fetch,    "sub_fetch");
      step(0, OP_R, 6'b100010, 0, 1, e_decode,   "sub_decode");
      step(0, OP_R, 6'b100010, 0, 1, e_rtex_sub, "sub_rtex");
      step(0, OP_R, 6'b100010, 0, 1, e_rtwb,     "sub_rtwb");

      // beq / bne with both zero polarities
      step(0, OP_BEQ, 6'd0, 1, 1, e_fetch,  "beq1_fetch");
      step(0, OP_BEQ, 6'd0, 1, 1, e_decode, "beq1_decode");
      step(0, OP_BEQ, 6'd0, 1, 1, e_beq_t,  "beq_taken");
      step(0, OP_BEQ, 6'd0, 0, 1, e_fetch,  "beq0_fetch");
      step(0, OP_BEQ, 6'd0, 0, 1, e_decode, "beq0_decode");
      step(0, OP_BEQ, 6'd0, 0, 1, e_beq_f,  "beq_not_taken");
      step(0, OP_BNE, 6'd0, 0, 1, e_fetch,  "bne0_fetch");
      step(0, OP_BNE, 6'd0, 0, 1, e_decode, "bne0_decode");
      step(0, OP_BNE, 6'd0, 0, 1, e_bne_t,  "bne_taken");
      step(0, OP_BNE, 6'd0, 1, 1, e_fetch,  "bne1_fetch");
      step(0, OP_BNE, 6'd0, 1, 1, e_decode, "bne1_decode");
      step(0, OP_BNE, 6'd0, 1, 1, e_bne_f,  "bne_not_taken");

      // FETCH stalls two cycles, then j
      step(0, OP_J, 6'd0, 0, 0, e_fetch_wait, "fetch_wait1");
      step(0, OP_J, 6'd0, 0, 0, e_fetch_wait, "fetch_wait2");
      step(0, OP_J, 6'd0, 0, 1, e_fetch,      "fetch_ready");
      step(0, OP_J, 6'd0, 0, 1, e_decode,     "j_decode");
      step(0, OP_J, 6'd0, 0, 1, e_jmp,        "j_jmp");

      // Unsupported opcode
      step(0, OP_BAD, 6'd0, 0, 1, e_fetch,      "badop_fetch");
      step(0, OP_BAD, 6'd0, 0, 1, e_decode_ill, "badop_decode");
      step(0, OP_BAD, 6'd0, 0, 1, e_fetch,      "badop_back_fetch");

      // lw with one wait cycle in MEMRD
      step(0, OP_LW, 6'd0, 0, 1, e_decode, "lww_decode");
      step(0, OP_LW, 6'd0, 0, 1, e_memadr, "lww_memadr");
      step(0, OP_LW, 6'd0, 0, 0, e_memrd,  "lww_memrd_wait");
      step(0, OP_LW, 6'd0, 0, 1, e_memrd,  "lww_memrd_done");
      step(0, OP_LW, 6'd0, 0, 1, e_memwb,  "lww_memwb");

      // addi complete, then addi aborted by reset in ADDIEX
      step(0, OP_ADDI, 6'd0, 0, 1, e_fetch,  "addi_fetch");
      step(0, OP_ADDI, 6'd0, 0, 1, e_decode, "addi_decode");
      step(0, OP_ADDI, 6'd0, 0, 1, e_addiex, "addi_ex");
      step(0, OP_ADDI, 6'd0, 0, 1, e_addiwb, "addi_wb");
      step(0, OP_ADDI, 6'd0, 0, 1, e_fetch,  "addi2_fetch");
      step(0, OP_ADDI, 6'd0, 0, 1, e_decode, "addi2_decode");
      rst = 1'b1;
      step(0, OP_ADDI, 6'd0, 0, 0, e_fetch_wait, "addi_reset_async");
      rst = 1'b0;
      step(0, OP_ADDI, 6'd0, 0, 0, e_fetch_wait, "addi_no_wb");

      // Reduced configuration: memready ignored, bne illegal
      rst = 1'b1;
      step(1, OP_BNE, 6'd0, 0, 0, e_fetch, "b_reset");
      rst = 1'b0;
      step(1, OP_BNE, 6'd0, 0, 0, e_fetch,      "b_fetch_mr_ignored");
      step(1, OP_BNE, 6'd0, 0, 0, e_decode_ill, "b_bne_illegal");
      step(1, OP_SW,  6'd0, 0, 0, e_fetch,      "b_after_illegal");
      step(1, OP_SW,  6'd0, 0, 0, e_decode,     "b_sw_decode");
      step(1, OP_SW,  6'd0, 0, 0, e_memadr,     "b_sw_memadr");
      step(1, OP_SW,  6'd0, 0, 0, e_memwr,      "b_sw_memwr");
      step(1, OP_SW,  6'd0, 0, 0, e_fetch,      "b_sw_done");

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
